// File: rtl/calc_entry_fsm.sv
// Calculator key-entry front end that feeds a binary-to-seven-segment converter.
// Define CALC_MUL_EN to make key C a multiply operator; otherwise C is ignored.
module calc_entry_fsm #(
  parameter int WIDTH      = 14,
  parameter int MAX_VAL    = 9999,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             key_ready,
  output logic [WIDTH-1:0] num,
  output logic             error,
  output logic             convert,
  input  logic             conv_done,
  output logic [2:0]       dbg_state_o
);

  // Key handshake: a key transfers on the posedge where key_valid && key_ready;
  // key_ready depends only on the state, never on key_valid or key_code.

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int RW = 2 * WIDTH;
  localparam logic [RW-1:0] MAX_R   = RW'(MAX_VAL);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);
  localparam logic [3:0] K_ADD = 4'hA;
  localparam logic [3:0] K_SUB = 4'hB;
`ifdef CALC_MUL_EN
  localparam logic [3:0] K_MUL = 4'hC;
`endif
  localparam logic [3:0] K_EQ  = 4'hE;
  localparam logic [3:0] K_CLR = 4'hF;

  typedef enum logic [2:0] {S_INIT, S_ENTRY, S_CONVERT, S_WAIT_DONE, S_ERR} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL} op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] entry_q, entry_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fresh_q, fresh_d;
  logic             error_q, error_d;
  logic             done_prev_q;

  logic [RW-1:0]    acc_w, entry_w, res_w;
  logic             res_err;
  logic             is_op;
  op_t              key_op;
  logic [WIDTH-1:0] digit_w, entry_step;
  logic             clr;

  // Pending operation applied to the accumulator, evaluated at double width.
  always_comb begin
    acc_w   = {{WIDTH{1'b0}}, acc_q};
    entry_w = {{WIDTH{1'b0}}, entry_q};
    res_err = 1'b0;
    case (op_q)
      OP_ADD: res_w = acc_w + entry_w;
      OP_SUB: begin
        res_w   = acc_w - entry_w;
        res_err = (acc_q < entry_q);
      end
`ifdef CALC_MUL_EN
      OP_MUL: res_w = acc_w * entry_w;
`endif
      default: res_w = entry_w;
    endcase
    if (res_w > MAX_R) res_err = 1'b1;
  end

  always_comb begin
    is_op  = 1'b1;
    key_op = OP_NONE;
    case (key_code)
      K_ADD: key_op = OP_ADD;
      K_SUB: key_op = OP_SUB;
`ifdef CALC_MUL_EN
      K_MUL: key_op = OP_MUL;
`endif
      default: is_op = 1'b0;
    endcase
  end

  assign digit_w    = WIDTH'(key_code);
  assign entry_step = entry_q * WIDTH'(10) + digit_w;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    entry_d = entry_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    fresh_d = fresh_q;
    error_d = error_q;
    clr     = 1'b0;
    case (state_q)
      S_INIT: state_d = S_CONVERT;
      S_ENTRY: begin
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            // A digit after equals starts a new operand; a full operand drops it.
            if (fresh_q || (cnt_q < MAX_CNT)) begin
              entry_d = fresh_q ? digit_w : entry_step;
              cnt_d   = fresh_q ? ONE_CNT : cnt_q + ONE_CNT;
              fresh_d = 1'b0;
              num_d   = entry_d;
              state_d = S_CONVERT;
            end
          end else if (is_op || (key_code == K_EQ)) begin
            state_d = S_CONVERT;
            if (res_err) begin
              error_d = 1'b1;
              num_d   = '0;
            end else begin
              acc_d = res_w[WIDTH-1:0];
              num_d = res_w[WIDTH-1:0];
            end
            if (is_op) begin
              op_d    = key_op;
              entry_d = '0;
              cnt_d   = '0;
              fresh_d = 1'b0;
            end else begin
              op_d    = OP_NONE;
              entry_d = res_w[WIDTH-1:0];
              fresh_d = 1'b1;
            end
          end else if (key_code == K_CLR) begin
            clr     = 1'b1;
            state_d = S_CONVERT;
          end
        end
      end
      S_CONVERT: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (conv_done && !done_prev_q) state_d = error_q ? S_ERR : S_ENTRY;
      end
      S_ERR: begin
        if (key_valid && (key_code == K_CLR)) begin
          clr     = 1'b1;
          state_d = S_CONVERT;
        end
      end
      default: state_d = S_INIT;
    endcase
    if (clr) begin
      op_d    = OP_NONE;
      acc_d   = '0;
      entry_d = '0;
      num_d   = '0;
      cnt_d   = '0;
      fresh_d = 1'b0;
      error_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      op_q        <= OP_NONE;
      acc_q       <= '0;
      entry_q     <= '0;
      num_q       <= '0;
      cnt_q       <= '0;
      fresh_q     <= 1'b0;
      error_q     <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      entry_q     <= entry_d;
      num_q       <= num_d;
      cnt_q       <= cnt_d;
      fresh_q     <= fresh_d;
      error_q     <= error_d;
      done_prev_q <= conv_done;
    end
  end

  assign key_ready   = (state_q == S_ENTRY) || (state_q == S_ERR);
  assign convert     = (state_q == S_CONVERT);
  assign num         = num_q;
  assign error       = error_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/calc_entry_fsm.md
Name: calc_entry_fsm

Overview:
- Calculator front end that sits directly upstream of the binary-to-seven-segment converter.
- Accepts key codes over a valid/ready handshake and accumulates a decimal operand.
- Applies add, subtract and, optionally, multiply, then drives the converter's number, error and convert inputs.
- Holds each displayed value stable until the converter reports completion.

Parameters:
- WIDTH, 14, width of num output and internal operand/accumulator registers.
- MAX_VAL, 9999, largest displayable value; any result above it is an error.
- MAX_DIGITS, 4, maximum number of digits accepted per operand.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- key_valid  input  1  key_code valid this cycle.
- key_code  input  4  0-9 digit, A add, B sub, C mul (optional), D reserved, E equals, F clear.
- key_ready  output  1  block can accept a key this cycle.
- num  output  WIDTH  value to display; drives converter num.
- error  output  1  error indication; drives converter error.
- convert  output  1  one-cycle start strobe to the converter.
- conv_done  input  1  converter completion (level); the rising edge is used.

Behaviour:
- Reset is asynchronous active-low; all registers clear immediately on rst_n=0.
- Reset values: key_ready=0, num=0, error=0, convert=0, state=INIT, acc=0, entry=0, digit count=0, pending op=NONE, fresh=0.
- States: INIT, ENTRY, CONVERT, WAIT_DONE, ERR.
- INIT: on the first clock after reset release, go to CONVERT so that 0 is displayed.
- Key acceptance:
  - A key is accepted on the posedge where key_valid && key_ready.
  - key_ready=1 only in ENTRY and ERR.
  - key_code is ignored whenever key_ready=0.
- Digit key in ENTRY:
  - If fresh=1 (the last key was equals): entry=d, count=1, fresh=0.
  - Else if count < MAX_DIGITS: entry=entry*10+d, count+1.
  - Else: the key is ignored; stay in ENTRY, no convert.
  - On an accepted digit, num=entry, updated on the same edge.
- Operator key A/B/C:
  - If pending op is NONE, result=entry; otherwise result = acc op entry.
  - Then acc=result, num=result, pending op=key, entry=0, count=0.
- Equals key E:
  - result computed as for an operator key.
  - acc=result, num=result, entry=result, pending op=NONE, fresh=1.
  - If pending op is already NONE, num=entry (re-display).
- Clear key F: all state returns to reset values except state; num=0, error=0.
- Reserved key D: ignored, no convert.
- Arithmetic and error:
  - Arithmetic is computed in a 2*WIDTH-bit intermediate.
  - Subtraction with a negative result is an error, as is any result > MAX_VAL.
  - On error: error=1, num=0, next state CONVERT, then from WAIT_DONE to ERR instead of ENTRY.
- Every accepted, non-ignored key moves ENTRY to CONVERT on the same edge.
- CONVERT: convert=1 for exactly one cycle; next state WAIT_DONE.
- WAIT_DONE:
  - Waits for a conv_done 0->1 transition, using a registered previous value.
  - A conv_done level already high on entry does not count.
  - Then go to ENTRY, or to ERR if error=1.
- num and error are stable from the convert cycle until WAIT_DONE exits.
- ERR: only F is acted on (clear, then CONVERT); all other keys are accepted and discarded.
- Simultaneous events: conv_done during CONVERT is ignored; key_valid outside ENTRY/ERR stalls the upstream source.
- Reset mid-operation (any state, including WAIT_DONE) aborts immediately; pending converter activity is ignored.

Optional Feature:
- Macro: CALC_MUL_EN.
- When defined: key C is a multiply operator; the 28-bit product is range-checked against MAX_VAL.
- When undefined: key C is treated as reserved and ignored (no convert); no multiplier is synthesised.

Test Plan:
- Reset release -> one convert pulse with num=0, error=0; after a conv_done rising edge, key_ready=1.
- Keys 1,2,3,4,5 -> num steps 1, 12, 123, 1234; the fifth digit is ignored (no convert, num=1234).
- Keys 1,2,A,3,0,E -> num=30 after A... then num=42 after E; error=0; then key 7 -> num=7 (fresh entry).
- Keys 5,B,9,E -> error=1, num=0, state ERR; key 3 is ignored; key F -> error=0, num=0, convert pulse.
- Keys 9,9,9,9,A,1,E -> overflow error (10000 > 9999); error=1, num=0.
- With CALC_MUL_EN: keys 1,2,C,1,2,E -> num=144. Without it: C is ignored and the keys yield num=1212. Also assert rst_n low during WAIT_DONE -> outputs clear immediately.
